// File: rtl/mc_ctrl.sv
// Multicycle MIPS-style control unit: decodes the opcode into per-state datapath
// controls and counts retired instructions.
module mc_ctrl #(
  parameter int unsigned EXT_OPS = 1,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic             mem_ready,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic             mem_write,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             alu_srcA,
  output logic             branch,
  output logic             branch_ne,
  output logic             zext,
  output logic [1:0]       alu_srcB,
  output logic [1:0]       pc_src,
  output logic [2:0]       alu_op,
  output logic             illegal,
  output logic             retire,
  output logic [CNT_W-1:0] retired_cnt
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXECUTE, S_ALUWB, S_BRANCH, S_IMMEX, S_IMMWB, S_JUMP
  } state_t;

  state_t state, state_nxt;
  logic   ext_en;

  assign ext_en = (EXT_OPS != 0);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= state_nxt;
  end

  // Next state and control decode
  always_comb begin
    state_nxt  = state;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_srcA   = 1'b0;
    branch     = 1'b0;
    branch_ne  = 1'b0;
    zext       = 1'b0;
    alu_srcB   = 2'b00;
    pc_src     = 2'b00;
    alu_op     = 3'b000;
    illegal    = 1'b0;
    retire     = 1'b0;

    case (state)
      S_FETCH: begin
        alu_srcB = 2'b01;
        ir_write = mem_ready;
        pc_write = mem_ready;
        if (mem_ready) state_nxt = S_DECODE;
      end
      S_DECODE: begin
        alu_srcB = 2'b11;
        case (op)
          OP_LW, OP_SW: state_nxt = S_MEMADR;
          OP_RTYPE:     state_nxt = S_EXECUTE;
          OP_BEQ:       state_nxt = S_BRANCH;
          OP_ADDI:      state_nxt = S_IMMEX;
          OP_J:         state_nxt = S_JUMP;
          OP_BNE: begin
            state_nxt = ext_en ? S_BRANCH : S_FETCH;
            illegal   = !ext_en;
          end
          OP_ANDI, OP_ORI: begin
            state_nxt = ext_en ? S_IMMEX : S_FETCH;
            illegal   = !ext_en;
          end
          default: begin
            state_nxt = S_FETCH;
            illegal   = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_srcA  = 1'b1;
        alu_srcB  = 2'b10;
        state_nxt = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord = 1'b1;
        if (mem_ready) state_nxt = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        state_nxt  = S_FETCH;
      end
      S_MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        retire    = mem_ready;
        if (mem_ready) state_nxt = S_FETCH;
      end
      S_EXECUTE: begin
        alu_srcA  = 1'b1;
        alu_op    = 3'b010;
        state_nxt = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        retire    = 1'b1;
        state_nxt = S_FETCH;
      end
      S_BRANCH: begin
        alu_srcA  = 1'b1;
        alu_op    = 3'b001;
        pc_src    = 2'b01;
        branch    = (op == OP_BEQ);
        branch_ne = (op == OP_BNE) && ext_en;
        retire    = 1'b1;
        state_nxt = S_FETCH;
      end
      S_IMMEX: begin
        alu_srcA  = 1'b1;
        alu_srcB  = 2'b10;
        case (op)
          OP_ANDI: alu_op = 3'b011;
          OP_ORI:  alu_op = 3'b100;
          default: alu_op = 3'b000;
        endcase
        zext      = (op == OP_ANDI) || (op == OP_ORI);
        state_nxt = S_IMMWB;
      end
      S_IMMWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_nxt = S_FETCH;
      end
      S_JUMP: begin
        pc_src    = 2'b10;
        pc_write  = 1'b1;
        retire    = 1'b1;
        state_nxt = S_FETCH;
      end
      default: state_nxt = S_FETCH;
    endcase

    // FETCH values already hold while in reset; suppress the strobes too
    if (reset) begin
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
      illegal   = 1'b0;
      retire    = 1'b0;
    end
  end

  // Retired-instruction counter, wraps naturally
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       retired_cnt <= '0;
    else if (retire) retired_cnt <= retired_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: directed scenarios plus random instruction streams checked
// against a per-instruction expected-cycle model.
module tb_mc_ctrl;

  localparam int unsigned CW = 4;

  localparam logic [5:0] RTYPE = 6'b000000, LW = 6'b100011, SW = 6'b101011,
                         BEQ = 6'b000100, BNE = 6'b000101, ADDI = 6'b001000,
                         ANDI = 6'b001100, ORI = 6'b001101, JMP = 6'b000010;

  typedef struct packed {
    logic iord, ir_write, pc_write, mem_write, reg_write, reg_dst, mem_to_reg;
    logic alu_srcA, branch, branch_ne, zext, illegal, retire;
    logic [1:0] alu_srcB, pc_src;
    logic [2:0] alu_op;
  } ctl_t;

  logic clk, reset;
  logic [5:0] op, op0;
  logic mem_ready, mr0;

  logic d1_iord, d1_irw, d1_pcw, d1_mw, d1_rw, d1_rd, d1_m2r, d1_sa, d1_br, d1_bne, d1_zx, d1_ill, d1_ret;
  logic [1:0] d1_sb, d1_ps;
  logic [2:0] d1_ao;
  logic [CW-1:0] d1_cnt;
  logic d0_iord, d0_irw, d0_pcw, d0_mw, d0_rw, d0_rd, d0_m2r, d0_sa, d0_br, d0_bne, d0_zx, d0_ill, d0_ret;
  logic [1:0] d0_sb, d0_ps;
  logic [2:0] d0_ao;
  logic [31:0] d0_cnt;

  ctl_t g1, g0;
  assign g1 = {d1_iord, d1_irw, d1_pcw, d1_mw, d1_rw, d1_rd, d1_m2r, d1_sa, d1_br, d1_bne, d1_zx, d1_ill, d1_ret, d1_sb, d1_ps, d1_ao};
  assign g0 = {d0_iord, d0_irw, d0_pcw, d0_mw, d0_rw, d0_rd, d0_m2r, d0_sa, d0_br, d0_bne, d0_zx, d0_ill, d0_ret, d0_sb, d0_ps, d0_ao};

  mc_ctrl #(.EXT_OPS(1), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
    .iord(d1_iord), .ir_write(d1_irw), .pc_write(d1_pcw), .mem_write(d1_mw),
    .reg_write(d1_rw), .reg_dst(d1_rd), .mem_to_reg(d1_m2r), .alu_srcA(d1_sa),
    .branch(d1_br), .branch_ne(d1_bne), .zext(d1_zx), .alu_srcB(d1_sb),
    .pc_src(d1_ps), .alu_op(d1_ao), .illegal(d1_ill), .retire(d1_ret),
    .retired_cnt(d1_cnt));

  mc_ctrl #(.EXT_OPS(0), .CNT_W(32)) dut0 (
    .clk(clk), .reset(reset), .op(op0), .mem_ready(mr0),
    .iord(d0_iord), .ir_write(d0_irw), .pc_write(d0_pcw), .mem_write(d0_mw),
    .reg_write(d0_rw), .reg_dst(d0_rd), .mem_to_reg(d0_m2r), .alu_srcA(d0_sa),
    .branch(d0_br), .branch_ne(d0_bne), .zext(d0_zx), .alu_srcB(d0_sb),
    .pc_src(d0_ps), .alu_op(d0_ao), .illegal(d0_ill), .retire(d0_ret),
    .retired_cnt(d0_cnt));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cnt1 = 0;
  logic [31:0] cnt0 = '0;
  ctl_t exp_q[$];
  bit   mr_q[$];

  function automatic bit legal(logic [5:0] o, bit ext);
    case (o)
      RTYPE, LW, SW, BEQ, ADDI, JMP: return 1'b1;
      BNE, ANDI, ORI:               return ext;
      default:                      return 1'b0;
    endcase
  endfunction

  function automatic bit rb();
    return bit'($urandom_range(1));
  endfunction

  task automatic push(ctl_t c, bit m);
    exp_q.push_back(c);
    mr_q.push_back(m);
  endtask

  // Expected per-cycle controls for one instruction, fw fetch waits, mw memory waits
  task automatic build(logic [5:0] o, bit ext, int fw, int mw);
    ctl_t c;
    for (int i = 0; i < fw; i++) begin c = '0; c.alu_srcB = 2'b01; push(c, 1'b0); end
    c = '0; c.alu_srcB = 2'b01; c.ir_write = 1'b1; c.pc_write = 1'b1; push(c, 1'b1);
    c = '0; c.alu_srcB = 2'b11; c.illegal = !legal(o, ext); push(c, rb());
    if (c.illegal) return;
    c = '0;
    case (o)
      LW, SW: begin
        c.alu_srcA = 1'b1; c.alu_srcB = 2'b10; push(c, rb());
        c = '0; c.iord = 1'b1; c.mem_write = (o == SW);
        for (int i = 0; i < mw; i++) push(c, 1'b0);
        c.retire = (o == SW); push(c, 1'b1);
        if (o == LW) begin
          c = '0; c.reg_write = 1'b1; c.mem_to_reg = 1'b1; c.retire = 1'b1; push(c, rb());
        end
      end
      RTYPE: begin
        c.alu_srcA = 1'b1; c.alu_op = 3'b010; push(c, rb());
        c = '0; c.reg_write = 1'b1; c.reg_dst = 1'b1; c.retire = 1'b1; push(c, rb());
      end
      BEQ, BNE: begin
        c.alu_srcA = 1'b1; c.alu_op = 3'b001; c.pc_src = 2'b01;
        c.branch = (o == BEQ); c.branch_ne = (o == BNE); c.retire = 1'b1; push(c, rb());
      end
      ADDI, ANDI, ORI: begin
        c.alu_srcA = 1'b1; c.alu_srcB = 2'b10; c.zext = (o != ADDI);
        c.alu_op = (o == ANDI) ? 3'b011 : (o == ORI) ? 3'b100 : 3'b000; push(c, rb());
        c = '0; c.reg_write = 1'b1; c.retire = 1'b1; push(c, rb());
      end
      default: begin
        c.pc_src = 2'b10; c.pc_write = 1'b1; c.retire = 1'b1; push(c, rb());
      end
    endcase
  endtask

  task automatic step(bit ext, ctl_t e, bit m);
    @(negedge clk);
    if (ext) mem_ready = m; else mr0 = m;
    #1;
    checks++;
    if (ext) begin
      assert (g1 === e) else begin failures++; $error("FAIL ctl_ext1 got=%h exp=%h t=%0t", g1, e, $time); end
      checks++;
      assert (d1_cnt === CW'(cnt1)) else begin failures++; $error("FAIL cnt_ext1 got=%0d exp=%0d t=%0t", d1_cnt, CW'(cnt1), $time); end
      if (e.retire) cnt1++;
    end else begin
      assert (g0 === e) else begin failures++; $error("FAIL ctl_ext0 got=%h exp=%h t=%0t", g0, e, $time); end
      checks++;
      assert (d0_cnt === cnt0) else begin failures++; $error("FAIL cnt_ext0 got=%0d exp=%0d t=%0t", d0_cnt, cnt0, $time); end
      if (e.retire) cnt0++;
    end
  endtask

  task automatic play(bit ext, logic [5:0] o, int n);
    if (ext) op = o; else op0 = o;
    for (int k = 0; k < n && exp_q.size() > 0; k++) step(ext, exp_q.pop_front(), mr_q.pop_front());
  endtask

  task automatic run_instr(bit ext, logic [5:0] o, int fw, int mw);
    build(o, ext, fw, mw);
    play(ext, o, 1000);
    @(negedge clk);
    mem_ready = 1'b0; mr0 = 1'b0;
  endtask

  // Asynchronous reset mid-cycle with mem_ready high, then release at a falling edge
  task automatic pulse_reset(string tag);
    ctl_t r;
    r = '0; r.alu_srcB = 2'b01;
    exp_q.delete(); mr_q.delete();
    #2;
    mem_ready = 1'b1; mr0 = 1'b1;
    reset = 1'b1;
    #1;
    cnt1 = 0; cnt0 = '0;
    checks++;
    assert (g1 === r) else begin failures++; $error("FAIL %s_ctl1 got=%h exp=%h", tag, g1, r); end
    checks++;
    assert (g0 === r) else begin failures++; $error("FAIL %s_ctl0 got=%h exp=%h", tag, g0, r); end
    checks++;
    assert (d1_cnt === CW'(0)) else begin failures++; $error("FAIL %s_cnt1 got=%0d exp=0", tag, d1_cnt); end
    checks++;
    assert (d0_cnt === 32'd0) else begin failures++; $error("FAIL %s_cnt0 got=%0d exp=0", tag, d0_cnt); end
    @(negedge clk);
    reset = 1'b0; mem_ready = 1'b0; mr0 = 1'b0;
  endtask

  initial begin
    logic [5:0] ops[9];
    logic [5:0] o;
    ops = '{RTYPE, LW, SW, BEQ, BNE, ADDI, ANDI, ORI, JMP};
    reset = 1'b0; mem_ready = 1'b0; mr0 = 1'b0; op = RTYPE; op0 = RTYPE;
    #1;
    pulse_reset("rst_init");

    // Directed scenarios
    run_instr(1'b1, LW, 0, 0);
    run_instr(1'b1, SW, 0, 3);
    run_instr(1'b1, ORI, 1, 0);
    run_instr(1'b1, BNE, 0, 0);
    run_instr(1'b1, ANDI, 0, 1);
    run_instr(1'b0, BNE, 0, 0);
    run_instr(1'b0, ANDI, 0, 0);
    run_instr(1'b0, ORI, 1, 0);
    run_instr(1'b0, LW, 1, 2);
    run_instr(1'b1, 6'b111111, 0, 0);

    // Abandon a load in its MEMRD wait, then a store in its MEMWR wait
    build(LW, 1'b1, 0, 3);
    play(1'b1, LW, 5);
    pulse_reset("rst_memrd");
    run_instr(1'b1, RTYPE, 0, 0);
    build(SW, 1'b1, 0, 3);
    play(1'b1, SW, 4);
    pulse_reset("rst_memwr");
    run_instr(1'b1, BEQ, 0, 0);

    // Counter wrap: 17 retirements on a 4-bit counter
    pulse_reset("rst_wrap");
    for (int i = 0; i < 17; i++) run_instr(1'b1, JMP, 0, 0);
    checks++;
    assert (d1_cnt === CW'(1)) else begin failures++; $error("FAIL wrap17 got=%0d exp=1", d1_cnt); end

    // Random instruction streams
    for (int i = 0; i < 160; i++) begin
      o = ($urandom_range(7) == 0) ? 6'($urandom_range(63)) : ops[$urandom_range(8)];
      run_instr(1'b1, o, int'($urandom_range(2)), int'($urandom_range(3)));
    end
    for (int i = 0; i < 40; i++) begin
      o = ($urandom_range(7) == 0) ? 6'($urandom_range(63)) : ops[$urandom_range(8)];
      run_instr(1'b0, o, int'($urandom_range(2)), int'($urandom_range(3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 The block SHALL have parameter EXT_OPS, default 1, meaning: 1 enables BNE/ANDI/ORI decode; 0 treats them as illegal.
REQ-002 The block SHALL have parameter CNT_W, default 32, meaning: width of the retired-instruction counter.
REQ-003 The block SHALL have port clk  input  1  meaning: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset  input  1  meaning: asynchronous, active-high reset.
REQ-005 The block SHALL have port op  input  6  meaning: opcode from the instruction register, stable from DECODE until the instruction retires.
REQ-006 The block SHALL have port mem_ready  input  1  meaning: memory access completes this cycle.
REQ-007 The block SHALL have ports iord, ir_write, pc_write, mem_write, reg_write, reg_dst, mem_to_reg, alu_srcA, branch, branch_ne, zext  output  1 each  meaning: datapath controls.
REQ-008 The block SHALL have ports alu_srcB  output  2  and pc_src  output  2  meaning: mux selects.
REQ-009 The block SHALL have port alu_op  output  3  meaning: 000 add, 001 sub, 010 funct, 011 and, 100 or.
REQ-010 The block SHALL have ports illegal, retire  output  1  and retired_cnt  output  CNT_W  meaning: status pulses and counter.

Function
REQ-011 Opcodes SHALL be RTYPE 000000, LW 100011, SW 101011, BEQ 000100, BNE 000101, ADDI 001000, ANDI 001100, ORI 001101, J 000010.
REQ-012 FSM states SHALL be FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, IMMEX, IMMWB, JUMP.
REQ-013 Outputs SHALL be combinational from state (plus op and mem_ready where stated); every control not listed for a state SHALL be 0.
REQ-014 FETCH: alu_srcB=01, alu_op=000, pc_src=00, ir_write=pc_write=mem_ready; stay until mem_ready=1, then DECODE.
REQ-015 DECODE: alu_srcB=11, alu_op=000; next: LW/SW->MEMADR, RTYPE->EXECUTE, BEQ/BNE->BRANCH, ADDI/ANDI/ORI->IMMEX, J->JUMP.
REQ-016 DECODE with any other opcode (or BNE/ANDI/ORI when EXT_OPS=0) SHALL assert illegal for that cycle and go to FETCH.
REQ-017 MEMADR: alu_srcA=1, alu_srcB=10, alu_op=000; LW->MEMRD, SW->MEMWR.
REQ-018 MEMRD: iord=1; hold until mem_ready=1, then MEMWB.
REQ-019 MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0; -> FETCH.
REQ-020 MEMWR: iord=1, mem_write=1 held every wait cycle; -> FETCH when mem_ready=1.
REQ-021 EXECUTE: alu_srcA=1, alu_srcB=00, alu_op=010; -> ALUWB. ALUWB: reg_write=1, reg_dst=1; -> FETCH.
REQ-022 BRANCH: alu_srcA=1, alu_srcB=00, alu_op=001, pc_src=01, branch=1 for BEQ, branch_ne=1 for BNE; -> FETCH.
REQ-023 IMMEX: alu_srcA=1, alu_srcB=10; alu_op 000/011/100 for ADDI/ANDI/ORI; zext=1 for ANDI/ORI; -> IMMWB. IMMWB: reg_write=1, reg_dst=0; -> FETCH.
REQ-024 JUMP: pc_src=10, pc_write=1; -> FETCH.
REQ-025 retire SHALL pulse 1 cycle in MEMWB, ALUWB, BRANCH, IMMWB, JUMP, and MEMWR when mem_ready=1; never for illegal.
REQ-026 retired_cnt SHALL increment by 1 on each clock edge with retire=1, wrapping from all-ones to 0.
REQ-027 Instruction latency with mem_ready tied 1 SHALL be: LW 5, SW 4, RTYPE 4, ADDI/ANDI/ORI 4, BEQ/BNE 3, J 3 cycles.

Reset
REQ-028 reset=1 SHALL immediately (asynchronously) force state=FETCH and retired_cnt=0.
REQ-029 While reset=1, ir_write, pc_write, mem_write, reg_write, illegal, retire SHALL be 0; other outputs SHALL take FETCH values.
REQ-030 Reset asserted mid-instruction (including during a MEMRD/MEMWR wait) SHALL abandon it without retire; first cycle after release is FETCH.

Verification
REQ-031 Scenario: mem_ready=1, op=LW -> states FETCH,DECODE,MEMADR,MEMRD,MEMWB; retire in cycle 5; retired_cnt 0->1.
REQ-032 Scenario: op=SW, mem_ready low 3 cycles in MEMWR -> mem_write=1 for 4 cycles, retire only on the mem_ready cycle.
REQ-033 Scenario: op=000101 with EXT_OPS=0 -> illegal=1 in DECODE, next FETCH, retired_cnt unchanged; with EXT_OPS=1 -> BRANCH with branch_ne=1, pc_src=01.
REQ-034 Scenario: op=ORI -> IMMEX shows alu_op=100, zext=1; IMMWB reg_write=1, reg_dst=0.
REQ-035 Scenario: CNT_W=4, retire 17 instructions -> retired_cnt=1 (wrap).
REQ-036 Scenario: reset pulsed during MEMRD wait -> all strobes 0 asynchronously, retired_cnt=0, FETCH after release.
